mem_access_stage: RTL

- Memory stage of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB boundary.
- Consumes the EX/MEM outputs: ALU result/address, store data, destination register and the 8-bit MEM control word.
- Performs loads and stores over a req/ack data-memory bus, stalling the upstream pipeline while an access is outstanding.
- Registers the write-back result into MEM/WB outputs.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_access_stage_if.sv | 25 ++
 rtl/load_align.sv | 28 ++
 rtl/mem_access_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Memory stage shared types: control word bit positions,
// access size encodings and the stage FSM state.
package mem_pkg;

  localparam int C_MEM_READ   = 0;
  localparam int C_MEM_WRITE  = 1;
  localparam int C_REG_WRITE  = 2;
  localparam int C_MEM_TO_REG = 3;
  localparam int C_SIZE_LO    = 4;
  localparam int C_SIZE_HI    = 5;
  localparam int C_LOAD_UNS   = 6;
  localparam int C_RSVD       = 7;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus. master = memory stage,
// slave = memory. rdata is valid only with ack.
interface mem_access_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr,
    output dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr,
    input  dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/load_align.sv
// Load lane extraction: rdata, addr[1:0], size, uns in;
// data out = selected lane sign/zero-extended to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  size_t       size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [15:0] h;
  logic [7:0]  b;

  always_comb begin
    h    = addr[1] ? rdata[31:16] : rdata[15:0];
    b    = rdata[{addr, 3'b000} +: 8];
    data = '0;
    unique case (size)
      SZ_WORD: data = rdata;
      SZ_HALF: data = {{16{~uns & h[15]}}, h};
      SZ_BYTE: data = {{24{~uns & b[7]}}, b};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on the dmem bus, stalls
// upstream while busy, registers the MEM/WB result.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [31:0] data_in,
  input  logic signed [31:0] mem_addr,
  input  logic [4:0]         rd_mem,
  input  logic [7:0]         control_MEM,
  output logic               stall,
  mem_access_stage_if.master dmem,
  output logic signed [31:0] wb_data,
  output logic [4:0]         rd_wb,
  output logic               reg_write_wb,
  output logic               mem_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    q_rd;
  logic          q_rw;
  logic          q_wr;
  size_t         q_sz;
  logic          q_uns;
  logic [1:0]    q_lo;

  logic        rd_en;
  logic        wr_en;
  logic        mem_op;
  size_t       sz;
  logic        aligned;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] ld_data;
  logic        tmo;
  logic        unused;

  assign unused = ^{control_MEM[C_MEM_TO_REG],
                    control_MEM[C_RSVD]};

  assign rd_en  = control_MEM[C_MEM_READ];
  assign wr_en  = control_MEM[C_MEM_WRITE];
  assign mem_op = rd_en | wr_en;
  assign sz     = size_t'(control_MEM[C_SIZE_HI:C_SIZE_LO]);
  assign tmo    = (cnt == TLAST);

  always_comb begin
    aligned = 1'b0;
    be_n    = '0;
    wd_n    = '0;
    unique case (sz)
      SZ_WORD: begin
        aligned = (mem_addr[1:0] == 2'b00);
        be_n    = 4'b1111;
        wd_n    = data_in;
      end
      SZ_HALF: begin
        aligned = ~mem_addr[0];
        be_n    = 4'b0011 << mem_addr[1:0];
        wd_n    = {2{data_in[15:0]}};
      end
      SZ_BYTE: begin
        aligned = 1'b1;
        be_n    = 4'b0001 << mem_addr[1:0];
        wd_n    = {4{data_in[7:0]}};
      end
      default: aligned = 1'b0;
    endcase
  end

  // Reset gates stall so it drops the instant reset asserts.
  always_comb begin
    stall = 1'b0;
    unique case (state)
      ST_IDLE: stall = mem_op & aligned;
      ST_BUSY: stall = ~dmem.dmem_ack & ~tmo;
      default: stall = 1'b0;
    endcase
    stall = stall & reset;
  end

  load_align u_align (
    .rdata (dmem.dmem_rdata),
    .addr  (q_lo),
    .size  (q_sz),
    .uns   (q_uns),
    .data  (ld_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      q_rd            <= '0;
      q_rw            <= 1'b0;
      q_wr            <= 1'b0;
      q_sz            <= SZ_WORD;
      q_uns           <= 1'b0;
      q_lo            <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
      wb_data         <= '0;
      rd_wb           <= '0;
      reg_write_wb    <= 1'b0;
      mem_err         <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!mem_op) begin
            wb_data      <= mem_addr;
            rd_wb        <= rd_mem;
            reg_write_wb <= control_MEM[C_REG_WRITE];
          end else if (!aligned) begin
            mem_err      <= 1'b1;
            reg_write_wb <= 1'b0;
          end else begin
            state           <= ST_BUSY;
            cnt             <= '0;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= wr_en;
            dmem.dmem_addr  <= {mem_addr[31:2], 2'b00};
            dmem.dmem_be    <= be_n;
            dmem.dmem_wdata <= wd_n;
            reg_write_wb    <= 1'b0;
            q_rd            <= rd_mem;
            q_rw            <= control_MEM[C_REG_WRITE];
            q_wr            <= wr_en;
            q_sz            <= sz;
            q_uns           <= control_MEM[C_LOAD_UNS];
            q_lo            <= mem_addr[1:0];
          end
        end
        ST_BUSY: begin
          if (dmem.dmem_ack) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            dmem.dmem_req <= 1'b0;
            rd_wb         <= q_rd;
            if (q_wr) begin
              reg_write_wb <= 1'b0;
            end else begin
              wb_data      <= ld_data;
              reg_write_wb <= q_rw;
            end
          end else if (tmo) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            dmem.dmem_req <= 1'b0;
            mem_err       <= 1'b1;
            reg_write_wb  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
